julia_engine: RTL and testbench
===============================

JULIA_ENGINE -- requirements
Module: julia_engine

Interface
REQ-001 SHALL have parameter IMG_W, default 640, horizontal pixel count.
REQ-002 SHALL have parameter IMG_H, default 480, vertical pixel count.
REQ-003 SHALL have parameter FRAC_W, default 16, fractional bits of the signed fixed-point word.
REQ-004 SHALL have parameter INT_W, default 16, integer bits (sign included); WORD_W = INT_W+FRAC_W.
REQ-005 SHALL have parameter MAX_ITER, default 100, iteration limit per pixel (1..255).
REQ-006 SHALL have parameter STEP_Q, default 410 (about 0.00625 in Q16.16), pixel-to-plane step.
REQ-007 SHALL have port CLK  in  1  sole clock; all logic on its rising edge.
REQ-008 SHALL have port RESET_N  in  1  reset, synchronous, active-low.
REQ-009 SHALL have port coord_in  in  WORD_W  signed fixed-point load value.
REQ-010 SHALL have port state  in  2  mode select: 00 load c_real, 01 load c_imag, 10 reserved, 11 run.
REQ-011 SHALL have port pix_ready  in  1  downstream accepts pixel.
REQ-012 SHALL have port x_draw / y_draw  out  10 each  pixel coordinates of the current result.
REQ-013 SHALL have port intensity  out  8  escape count, 0 = bounded.
REQ-014 SHALL have port pix_valid  out  1  result valid.
REQ-015 SHALL have port calculating  out  1  high from frame start until the last pixel is accepted.
REQ-016 SHALL have port frame_done  out  1  single-cycle pulse after the last pixel is accepted.

Function
REQ-017 SHALL use FSM IDLE->INIT->ITER->OUT, then back to INIT or to DONE; DONE->IDLE when state != 11.
REQ-018 IDLE SHALL latch coord_in into c_real (state 00) or c_imag (state 01) every cycle; loads SHALL be ignored in all other FSM states.
REQ-019 IDLE with state==11 SHALL clear x and y to 0 and go to INIT; the clear completes the transition in one cycle.
REQ-020 INIT (1 cycle) SHALL set zr=(x-IMG_W/2)*STEP_Q, zi=(y-IMG_H/2)*STEP_Q, n=0.
REQ-021 ITER SHALL first test the escape condition |zr|+|zi| > 4.0 and go to OUT with intensity=n if true.
REQ-022 If ITER does not escape and n==MAX_ITER, it SHALL go to OUT with intensity=0.
REQ-023 Otherwise ITER SHALL update zr'=((zr*zr-zi*zi)>>>FRAC_W)+c_real and zi'=((2*zr*zi)>>>FRAC_W)+c_imag, and set n=n+1.
REQ-024 The ITER update SHALL take one cycle per iteration, with products 2*WORD_W wide and results truncated to WORD_W.
REQ-025 OUT SHALL hold pix_valid=1 with x_draw, y_draw and intensity stable until the cycle where pix_ready=1.
REQ-026 On the OUT handshake, x SHALL advance row-major; x wraps at IMG_W-1 and increments y.
REQ-027 Accepting the pixel (IMG_W-1, IMG_H-1) SHALL go to DONE, drop calculating and pulse frame_done once.
REQ-028 The engine SHALL not re-run while in DONE even if state stays 11; a new frame requires state!=11 and then 11 again.
REQ-029 Per-pixel latency SHALL be 1 (INIT) + n+1 (ITER) cycles to pix_valid.

Reset
REQ-030 When RESET_N=0 at a clock edge, the FSM SHALL go to IDLE.
REQ-031 Reset SHALL clear x, y, n, zr, zi, c_real, c_imag, intensity, pix_valid, calculating and frame_done to 0.
REQ-032 Reset SHALL abort any frame immediately, with no frame_done pulse.

Configuration
REQ-033 With JULIA_ZOOM_EN defined, state 10 in IDLE SHALL load coord_in into a step register, and INIT SHALL use that register instead of STEP_Q.
REQ-034 With JULIA_ZOOM_EN defined, the step register SHALL reset to STEP_Q.
REQ-035 Without JULIA_ZOOM_EN, state 10 SHALL be ignored and STEP_Q SHALL be the only step.

Structure
REQ-036 Package julia_pkg SHALL hold the fixed_t typedef, the FSM state enum, the ESC_LIMIT constant (4.0 in fixed point) and the mode encodings.
REQ-037 One sub-module, julia_iter_dp, SHALL implement the combinational step: inputs z and c, outputs z' and escape flag.

Verification
REQ-038 Reset then run with IMG_W=4, IMG_H=2, STEP_Q=1.0 and c=0 -> pixel (0,0) SHALL give intensity=1, with pix_valid 3 cycles after INIT.
REQ-039 Same setup, pixel (2,1), where z0=0 -> intensity=0 after exactly MAX_ITER+1 ITER cycles.
REQ-040 Hold pix_ready=0 for 5 cycles on the first pixel -> outputs stable, and x does not advance until pix_ready=1.
REQ-041 Full 4x2 frame with pix_ready=1 -> 8 handshakes, one frame_done pulse, and no restart while state stays 11.
REQ-042 Assert RESET_N=0 during ITER on pixel 3 -> next cycle IDLE, all outputs 0, and no frame_done.
REQ-043 state=00 with coord_in=0x0001_0000 during run -> c_real unchanged; the load takes effect only in IDLE.

Source files
------------

// File: rtl/julia_pkg.sv
// Shared types and constants for the Julia-set pixel engine.
//   fixed_t       : signed Q16.16 word of the default build
//   fsm_e         : engine sequencing states
//   ESC_LIMIT     : escape radius (4.0) in the default fixed-point format
//   ESC_LIMIT_INT : escape radius as an integer, for other FRAC_W settings
//   MODE_*        : encodings of the 2-bit `state` mode-select input
package julia_pkg;

   localparam int FRAC_W_DEF = 16;
   localparam int INT_W_DEF  = 16;
   localparam int WORD_W_DEF = INT_W_DEF + FRAC_W_DEF;

   typedef logic signed [WORD_W_DEF-1:0] fixed_t;

   localparam int     ESC_LIMIT_INT = 4;
   localparam fixed_t ESC_LIMIT     = fixed_t'(ESC_LIMIT_INT << FRAC_W_DEF);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_ITER,
      S_OUT,
      S_DONE
   } fsm_e;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_LOAD_CR = 2'b00;
   localparam mode_t MODE_LOAD_CI = 2'b01;
   localparam mode_t MODE_ZOOM    = 2'b10;
   localparam mode_t MODE_RUN     = 2'b11;

endpackage

// File: rtl/julia_iter_dp.sv
// Combinational Julia iteration step: z' = z^2 + c, plus escape test on
// the incoming z (|zr| + |zi| > 4.0).
//   zr, zi           : current z (signed fixed point)
//   cr, ci           : constant c
//   zr_next, zi_next : next z, truncated back to the word width
//   escape           : incoming z is already outside the escape radius
module julia_iter_dp
   import julia_pkg::*;
#(
   parameter int FRAC_W = 16,
   parameter int INT_W  = 16
) (
   input  logic signed [INT_W+FRAC_W-1:0] zr,
   input  logic signed [INT_W+FRAC_W-1:0] zi,
   input  logic signed [INT_W+FRAC_W-1:0] cr,
   input  logic signed [INT_W+FRAC_W-1:0] ci,
   output logic signed [INT_W+FRAC_W-1:0] zr_next,
   output logic signed [INT_W+FRAC_W-1:0] zi_next,
   output logic                           escape
);

   localparam int WORD_W = INT_W + FRAC_W;
   localparam int PROD_W = 2 * WORD_W;
   localparam logic [WORD_W+1:0] LIMIT = (WORD_W+2)'(ESC_LIMIT_INT) << FRAC_W;

   logic signed [PROD_W-1:0] zr_w, zi_w;
   logic signed [PROD_W-1:0] p_rr, p_ii, p_ri;
   logic signed [PROD_W-1:0] re_full, im_full;
   logic        [WORD_W:0]   abs_r, abs_i;
   logic        [WORD_W+1:0] mag;

   always_comb begin
      zr_w    = {{WORD_W{zr[WORD_W-1]}}, zr};
      zi_w    = {{WORD_W{zi[WORD_W-1]}}, zi};
      p_rr    = zr_w * zr_w;
      p_ii    = zi_w * zi_w;
      p_ri    = zr_w * zi_w;
      re_full = p_rr - p_ii;
      // 2*zr*zi wraps inside the double-width product, like the plain multiply
      im_full = p_ri <<< 1;
      zr_next = WORD_W'(re_full >>> FRAC_W) + cr;
      zi_next = WORD_W'(im_full >>> FRAC_W) + ci;

      // one extra bit so the magnitude of the most negative word is exact
      abs_r   = zr[WORD_W-1] ? -{zr[WORD_W-1], zr} : {zr[WORD_W-1], zr};
      abs_i   = zi[WORD_W-1] ? -{zi[WORD_W-1], zi} : {zi[WORD_W-1], zi};
      mag     = {1'b0, abs_r} + {1'b0, abs_i};
      escape  = (mag > LIMIT);
   end

endmodule

// File: rtl/julia_engine.sv
// Julia-set frame engine: walks every pixel of an IMG_W x IMG_H frame in
// row-major order, iterates z = z^2 + c per pixel and hands the escape count
// out through a valid/ready pixel port.
//   CLK, RESET_N         : clock, synchronous active-low reset
//   coord_in             : value loaded into c_real / c_imag (/ step) in IDLE
//   state                : 00 load c_real, 01 load c_imag, 10 load step, 11 run
//   pix_ready            : downstream accepts the presented pixel
//   x_draw, y_draw       : coordinates of the presented pixel
//   intensity            : escape count, 0 when the pixel stayed bounded
//   pix_valid            : pixel result valid
//   calculating          : frame in progress
//   frame_done           : one-cycle pulse after the last pixel is accepted
// Optional feature: JULIA_ZOOM_EN adds a run-time step register loaded with
// mode 10; without it mode 10 is ignored and STEP_Q is fixed.
//
// state  | meaning
// IDLE   | load c / step from coord_in, wait for run mode
// INIT   | seed z from pixel position, clear iteration count
// ITER   | one z update per cycle until escape or MAX_ITER
// OUT    | present pixel, wait for pix_ready, advance x/y
// DONE   | frame finished, wait for run mode to drop
module julia_engine
   import julia_pkg::*;
#(
   parameter int IMG_W    = 640,
   parameter int IMG_H    = 480,
   parameter int FRAC_W   = 16,
   parameter int INT_W    = 16,
   parameter int MAX_ITER = 100,
   parameter int STEP_Q   = 410
) (
   input  logic                           CLK,
   input  logic                           RESET_N,
   input  logic signed [INT_W+FRAC_W-1:0] coord_in,
   input  logic        [1:0]              state,
   input  logic                           pix_ready,
   output logic        [9:0]              x_draw,
   output logic        [9:0]              y_draw,
   output logic        [7:0]              intensity,
   output logic                           pix_valid,
   output logic                           calculating,
   output logic                           frame_done
);

   localparam int WORD_W = INT_W + FRAC_W;

   fsm_e fsm_q, fsm_d;

   logic        [9:0]        x_q, y_q;
   logic        [7:0]        n_q;
   logic signed [WORD_W-1:0] zr_q, zi_q, cr_q, ci_q;
   logic        [7:0]        intensity_q;
   logic                     pix_valid_q, calc_q, done_q;

   logic signed [WORD_W-1:0] step_cur;
   logic signed [WORD_W-1:0] x_off, y_off, zr_init, zi_init;
   logic signed [WORD_W-1:0] zr_next, zi_next;
   logic                     escape, max_hit, last_x, last_pix;

`ifdef JULIA_ZOOM_EN
   logic signed [WORD_W-1:0] step_reg;
   assign step_cur = step_reg;
`else
   assign step_cur = WORD_W'(STEP_Q);
`endif

   julia_iter_dp #(
      .FRAC_W (FRAC_W),
      .INT_W  (INT_W)
   ) u_iter_dp (
      .zr      (zr_q),
      .zi      (zi_q),
      .cr      (cr_q),
      .ci      (ci_q),
      .zr_next (zr_next),
      .zi_next (zi_next),
      .escape  (escape)
   );

   always_comb begin
      x_off    = WORD_W'(x_q) - WORD_W'(IMG_W / 2);
      y_off    = WORD_W'(y_q) - WORD_W'(IMG_H / 2);
      zr_init  = x_off * step_cur;
      zi_init  = y_off * step_cur;
      max_hit  = (n_q == 8'(MAX_ITER));
      last_x   = (x_q == 10'(IMG_W - 1));
      last_pix = last_x && (y_q == 10'(IMG_H - 1));
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) fsm_q <= S_IDLE;
      else          fsm_q <= fsm_d;
   end

   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         S_IDLE: if (state == MODE_RUN) fsm_d = S_INIT;
         S_INIT: fsm_d = S_ITER;
         S_ITER: if (escape || max_hit) fsm_d = S_OUT;
         S_OUT:  if (pix_ready) fsm_d = last_pix ? S_DONE : S_INIT;
         S_DONE: if (state != MODE_RUN) fsm_d = S_IDLE;
         default: fsm_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         x_q         <= '0;
         y_q         <= '0;
         n_q         <= '0;
         zr_q        <= '0;
         zi_q        <= '0;
         cr_q        <= '0;
         ci_q        <= '0;
         intensity_q <= '0;
         pix_valid_q <= 1'b0;
         calc_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef JULIA_ZOOM_EN
         step_reg    <= WORD_W'(STEP_Q);
`endif
      end else begin
         done_q <= 1'b0;
         case (fsm_q)
            S_IDLE: begin
               case (state)
                  MODE_LOAD_CR: cr_q <= coord_in;
                  MODE_LOAD_CI: ci_q <= coord_in;
`ifdef JULIA_ZOOM_EN
                  MODE_ZOOM:    step_reg <= coord_in;
`endif
                  MODE_RUN: begin
                     x_q    <= '0;
                     y_q    <= '0;
                     calc_q <= 1'b1;
                  end
                  default: ;
               endcase
            end
            S_INIT: begin
               zr_q <= zr_init;
               zi_q <= zi_init;
               n_q  <= '0;
            end
            S_ITER: begin
               // escape is tested on the incoming z, before any update
               if (escape) begin
                  intensity_q <= n_q;
                  pix_valid_q <= 1'b1;
               end else if (max_hit) begin
                  intensity_q <= '0;
                  pix_valid_q <= 1'b1;
               end else begin
                  zr_q <= zr_next;
                  zi_q <= zi_next;
                  n_q  <= n_q + 8'd1;
               end
            end
            S_OUT: begin
               if (pix_ready) begin
                  pix_valid_q <= 1'b0;
                  if (last_x) begin
                     x_q <= '0;
                     y_q <= last_pix ? 10'd0 : y_q + 10'd1;
                  end else begin
                     x_q <= x_q + 10'd1;
                  end
                  if (last_pix) begin
                     calc_q <= 1'b0;
                     done_q <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign x_draw      = x_q;
   assign y_draw      = y_q;
   assign intensity   = intensity_q;
   assign pix_valid   = pix_valid_q;
   assign calculating = calc_q;
   assign frame_done  = done_q;

endmodule

// File: tb/tb_julia_engine.sv
// Self-checking bench for julia_engine on a 4x2 frame with a 1.0 step.
// Stimulus pushes model-predicted pixels into a queue; a monitor pops and
// compares on every pixel handshake.
module tb_julia_engine;

   localparam int IMG_W    = 4;
   localparam int IMG_H    = 2;
   localparam int FRAC_W   = 16;
   localparam int INT_W    = 16;
   localparam int MAX_ITER = 20;
   localparam int ONE      = 65536;
   localparam int STEP_Q   = ONE;
   localparam int NPIX     = IMG_W * IMG_H;

   logic               CLK = 1'b0;
   logic               RESET_N = 1'b0;
   logic signed [31:0] coord_in = '0;
   logic        [1:0]  state = 2'b10;
   logic               pix_ready = 1'b1;
   logic        [9:0]  x_draw, y_draw;
   logic        [7:0]  intensity;
   logic               pix_valid, calculating, frame_done;

   always #5 CLK = ~CLK;

   julia_engine #(
      .IMG_W    (IMG_W),
      .IMG_H    (IMG_H),
      .FRAC_W   (FRAC_W),
      .INT_W    (INT_W),
      .MAX_ITER (MAX_ITER),
      .STEP_Q   (STEP_Q)
   ) dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .coord_in    (coord_in),
      .state       (state),
      .pix_ready   (pix_ready),
      .x_draw      (x_draw),
      .y_draw      (y_draw),
      .intensity   (intensity),
      .pix_valid   (pix_valid),
      .calculating (calculating),
      .frame_done  (frame_done)
   );

   typedef struct {
      int x;
      int y;
      int inten;
   } pix_t;

   pix_t exp_q[$];
   pix_t mon_e;
   int   exp_lat[NPIX];
   int   n_vec = 0;
   int   n_err = 0;
   int   fd_count = 0;
   int   cur_cr = 0;
   int   cur_ci = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Straight escape-time evaluation of one pixel; iters counts ITER cycles.
   function automatic void model_pixel(input int px, input int py, input int cr, input int ci,
                                       output int inten, output int iters);
      int     zr, zi, n;
      longint mag, re, im;
      zr    = (px - IMG_W / 2) * STEP_Q;
      zi    = (py - IMG_H / 2) * STEP_Q;
      n     = 0;
      iters = 0;
      inten = 0;
      for (int k = 0; k <= MAX_ITER + 1; k++) begin
         iters++;
         mag = (zr < 0 ? -longint'(zr) : longint'(zr)) + (zi < 0 ? -longint'(zi) : longint'(zi));
         if (mag > longint'(4 * ONE)) begin
            inten = n;
            return;
         end
         if (n == MAX_ITER) begin
            inten = 0;
            return;
         end
         re = longint'(zr) * longint'(zr) - longint'(zi) * longint'(zi);
         im = 2 * longint'(zr) * longint'(zi);
         zr = int'(re >>> FRAC_W) + cr;
         zi = int'(im >>> FRAC_W) + ci;
         n++;
      end
   endfunction

   always @(negedge CLK) begin
      if (RESET_N && frame_done) fd_count++;
      if (RESET_N && pix_valid && pix_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pixel", 64'(pix_valid), 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("pix_x", 64'(x_draw), 64'(mon_e.x));
            chk("pix_y", 64'(y_draw), 64'(mon_e.y));
            chk("pix_intensity", 64'(intensity), 64'(mon_e.inten));
         end
      end
   end

   task automatic load_c(input int cr, input int ci);
      state = 2'b00; coord_in = cr;
      @(posedge CLK); #1;
      state = 2'b01; coord_in = ci;
      @(posedge CLK); #1;
      state = 2'b10; coord_in = $urandom;
      @(posedge CLK); #1;
      cur_cr = cr;
      cur_ci = ci;
   endtask

   task automatic push_frame();
      pix_t e;
      int   inten, iters;
      for (int p = 0; p < NPIX; p++) begin
         model_pixel(p % IMG_W, p / IMG_W, cur_cr, cur_ci, inten, iters);
         e.x = p % IMG_W;
         e.y = p / IMG_W;
         e.inten = inten;
         exp_q.push_back(e);
         exp_lat[p] = 1 + iters;
      end
   endtask

   task automatic wait_valid(input int p);
      int cnt = 0;
      while (pix_valid !== 1'b1 && cnt < 300) begin
         @(posedge CLK); #1;
         cnt++;
      end
      chk($sformatf("latency_p%0d", p), 64'(cnt), 64'(exp_lat[p]));
   endtask

   task automatic handshake(input bit rand_ready);
      bit r;
      bit taken = 1'b0;
      int tries = 0;
      while (!taken) begin
         r = (rand_ready && tries < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
         pix_ready = r;
         @(posedge CLK); #1;
         tries++;
         taken = r;
      end
      pix_ready = 1'b1;
   endtask

   task automatic run_frame(input bit hold_first, input bit rand_ready, input bit mid_load);
      logic [27:0] rec;
      int          fd0;
      push_frame();
      fd0 = fd_count;
      state = 2'b11;
      @(posedge CLK); #1;
      chk("calc_start", 64'(calculating), 64'd1);
      for (int p = 0; p < NPIX; p++) begin
         wait_valid(p);
         if (p == 0 && hold_first) begin
            pix_ready = 1'b0;
            rec = {x_draw, y_draw, intensity};
            repeat (5) begin
               @(posedge CLK); #1;
               chk("hold_stable", 64'({pix_valid, x_draw, y_draw, intensity}), 64'({1'b1, rec}));
            end
         end
         handshake(rand_ready);
         if (p == 0 && mid_load) begin
            state = 2'b00;
            coord_in = 32'h0001_0000;
         end
      end
      chk("frame_done_pulse", 64'(frame_done), 64'd1);
      chk("calc_end", 64'(calculating), 64'd0);
      repeat (10) @(posedge CLK);
      #1;
      chk("no_restart", 64'({pix_valid, calculating, frame_done}), 64'd0);
      chk("frame_done_count", 64'(fd_count - fd0), 64'd1);
      state = 2'b10;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
   endtask

   task automatic abort_frame();
      int fd0;
      push_frame();
      state = 2'b11;
      @(posedge CLK); #1;
      for (int p = 0; p < 3; p++) begin
         wait_valid(p);
         handshake(1'b0);
      end
      @(posedge CLK); #1;
      chk("p3_iterating", 64'({pix_valid, x_draw}), 64'({1'b0, 10'd3}));
      fd0 = fd_count;
      state = 2'b10;
      coord_in = 32'h7654_3210;
      RESET_N = 1'b0;
      @(posedge CLK); #1;
      chk("abort_outputs", 64'({x_draw, y_draw, intensity, pix_valid, calculating, frame_done}), 64'd0);
      RESET_N = 1'b1;
      exp_q.delete();
      cur_cr = 0;
      cur_ci = 0;
      repeat (5) @(posedge CLK);
      #1;
      chk("abort_no_frame_done", 64'(fd_count - fd0), 64'd0);
      chk("abort_idle", 64'({pix_valid, calculating}), 64'd0);
   endtask

   initial begin
      RESET_N = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_x_draw", 64'(x_draw), 64'd0);
      chk("rst_y_draw", 64'(y_draw), 64'd0);
      chk("rst_intensity", 64'(intensity), 64'd0);
      chk("rst_pix_valid", 64'(pix_valid), 64'd0);
      chk("rst_calculating", 64'(calculating), 64'd0);
      chk("rst_frame_done", 64'(frame_done), 64'd0);
      RESET_N = 1'b1;
      @(posedge CLK); #1;

      // c = 0: pixel (0,0) escapes with count 1, pixel (2,1) runs to the limit
      load_c(0, 0);
      run_frame(1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 5; i++) begin
         load_c(int'($urandom_range(0, 3 * ONE)) - (3 * ONE) / 2,
                int'($urandom_range(0, 3 * ONE)) - (3 * ONE) / 2);
         run_frame(1'b0, 1'b1, 1'b0);
      end

      load_c(int'($urandom_range(0, 2 * ONE)) - ONE, int'($urandom_range(0, 2 * ONE)) - ONE);
      run_frame(1'b0, 1'b0, 1'b1);

      load_c(int'($urandom_range(0, 2 * ONE)) - ONE, int'($urandom_range(0, 2 * ONE)) - ONE);
      abort_frame();

      // reset cleared c and mode 10 loads nothing, so this frame runs with c = 0
      run_frame(1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
